dds_sweep_phase_gen: RTL and testbench
======================================

// Module: dds_sweep_phase_gen
// PURPOSE
//   Next-generation DDS phase generator feeding the sine/cosine ROM stage. Adds runtime-loadable
//   FCW via valid/ready handshake, linear and triangle frequency sweep, per-config phase offset,
//   and optional LFSR phase dither, with phase-continuous retuning. Drives the ROM address/quadrant path.
// PARAMETERS
//   ACC_BITS     32  phase accumulator / FCW width
//   PHASE_BITS   13  output phase width (ROM_ADDR_BITS + 2 quadrant bits)
//   DITHER_BITS  19  LFSR dither width added below the phase LSB; must be <= ACC_BITS-PHASE_BITS
//   STEP_BITS    24  sweep step width (zero-extended to ACC_BITS)
// PORTS
//   CLK            in   1           clock
//   RSTN           in   1           asynchronous active-low reset
//   cfg_valid      in   1           config request
//   cfg_ready      out  1           config accept; handshake fires when cfg_valid & cfg_ready
//   cfg_mode       in   2           00 fixed, 01 sweep-up-wrap, 10 triangle, 11 reserved (= fixed)
//   cfg_fcw_start  in   ACC_BITS    fixed FCW / sweep lower bound
//   cfg_fcw_stop   in   ACC_BITS    sweep upper bound
//   cfg_step       in   STEP_BITS   FCW increment per enabled cycle
//   cfg_phase_off  in   PHASE_BITS  phase offset added to output phase
//   cfg_seed       in   32          LFSR seed, loaded on accepted config (0 is replaced by 1)
//   dither_ctrl    in   1           1 = add LFSR dither before truncation
//   enable         in   1           advance accumulator/sweep/LFSR
//   phase_o        out  PHASE_BITS  registered phase to ROM stage
//   phase_valid    out  1           phase_o valid
//   fcw_o          out  ACC_BITS    FCW currently in use
//   sweep_done     out  1           1-cycle pulse at sweep wrap or triangle turn-around
//   cfg_err        out  1           1-cycle pulse: sweep config rejected
// BEHAVIOUR
//   Reset: acc=0, fcw_o=0, phase_o=0, phase_valid=0, sweep_done=0, cfg_err=0, cfg_ready=1, lfsr=32'h1, state=IDLE.
//   States: IDLE, LOAD, FIXED, SWEEP_UP, SWEEP_DN.
//   - cfg_ready=1 in every state except LOAD. Accepted cfg -> LOAD (1 cycle: latch fields, fcw_o<=start,
//     lfsr<=seed) -> FIXED (mode 00/11), SWEEP_UP (01/10). acc is NOT cleared: phase continuous.
//   - Sweep cfg with start>=stop or step==0: cfg_err pulses in LOAD cycle, fields discarded, previous
//     state and fcw_o resume unchanged.
//   - Per enabled cycle: acc <= acc + fcw_o (mod 2^ACC_BITS, wrap silent).
//   - SWEEP_UP: fcw_o += step; if result >= stop: mode 01 -> fcw_o<=start, sweep_done=1, stay;
//     mode 10 -> fcw_o<=stop, sweep_done=1, go SWEEP_DN. Compare done at ACC_BITS+1 width (no overflow).
//   - SWEEP_DN: fcw_o -= step; if result <= start (or underflows) -> fcw_o<=start, sweep_done=1, SWEEP_UP.
//   - LFSR: 32-bit Galois, taps x^32+x^22+x^2+x+1, steps on enabled cycles only.
//   - phase_o <= (acc + (dither_ctrl ? lfsr[DITHER_BITS-1:0] : 0))[ACC_BITS-1 -: PHASE_BITS] + phase_off,
//     mod 2^PHASE_BITS; dither sum wraps mod 2^ACC_BITS. Uses pre-update acc: latency 1 cycle.
//   - phase_valid <= enable (1-cycle latency). enable=0: acc, fcw_o, lfsr, state hold; phase_o holds.
//   - IDLE: no accumulation, phase_valid=0 regardless of enable, until first accepted config.
//   - cfg accepted same cycle as sweep bound hit: sweep_done still pulses, then LOAD applies new cfg.
//   - RSTN low mid-sweep: all registers return to reset values immediately (async).
// TESTING
//   1 fixed: mode00 start=32'h0033_3333, off=0, no dither, 1000 cycles -> acc(n)=n*start, phase_o=acc[31:19].
//   2 retune: mid-run load start=32'h0013_3333 -> phase_o continuous (no jump), fcw_o changes after LOAD.
//   3 wrap sweep: mode01 start=100, stop=1000, step=300 -> fcw_o 100,400,700,100..., sweep_done each 3rd.
//   4 triangle: mode10 start=0, stop=900, step=300 -> 0,300,600,900,600,300,0,300; done at 900 and 0.
//   5 errors/edges: mode01 start=stop=500 -> cfg_err pulse, fcw_o unchanged; seed=0 -> lfsr=1; enable
//     low 10 cycles -> all hold, phase_valid=0; RSTN pulse mid-sweep -> all outputs reset values.
//   6 dither: dither_ctrl=1, seed=1234567, fcw=32'h0033_3333 -> phase_o vs golden model bit-exact 10k cycles.

Source files
------------

// File: rtl/dds_sweep_phase_gen_if.sv
// Configuration channel of the DDS sweep phase generator.
//   cfg_valid/cfg_ready : request/accept handshake, fires on cfg_valid & cfg_ready
//   cfg_mode            : 00 fixed, 01 sweep-up-wrap, 10 triangle, 11 fixed
//   cfg_fcw_start/stop  : fixed FCW or sweep lower bound / sweep upper bound
//   cfg_step            : FCW increment per enabled cycle while sweeping
//   cfg_phase_off       : offset added to the output phase
//   cfg_seed            : dither LFSR seed (0 is replaced by 1)
interface dds_sweep_phase_gen_if #(
    parameter int unsigned ACC_BITS   = 32,
    parameter int unsigned PHASE_BITS = 13,
    parameter int unsigned STEP_BITS  = 24
);
    logic                  cfg_valid;
    logic                  cfg_ready;
    logic [1:0]            cfg_mode;
    logic [ACC_BITS-1:0]   cfg_fcw_start;
    logic [ACC_BITS-1:0]   cfg_fcw_stop;
    logic [STEP_BITS-1:0]  cfg_step;
    logic [PHASE_BITS-1:0] cfg_phase_off;
    logic [31:0]           cfg_seed;

    modport master (
        output cfg_valid, cfg_mode, cfg_fcw_start, cfg_fcw_stop,
               cfg_step, cfg_phase_off, cfg_seed,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_mode, cfg_fcw_start, cfg_fcw_stop,
               cfg_step, cfg_phase_off, cfg_seed,
        output cfg_ready
    );
endinterface

// File: rtl/dds_sweep_phase_gen.sv
// DDS phase generator with runtime-loadable FCW, linear/triangle frequency
// sweep, phase offset and optional LFSR dither. Retuning never clears the
// accumulator, so the output phase stays continuous.
// Ports:
//   CLK, RSTN    : clock, asynchronous active-low reset
//   cfg          : configuration channel (slave side)
//   dither_ctrl  : 1 = add LFSR dither below the phase LSB before truncation
//   enable       : advance accumulator, sweep and LFSR
//   phase_o      : registered phase to the ROM stage (1-cycle latency)
//   phase_valid  : phase_o valid
//   fcw_o        : FCW currently in use
//   sweep_done   : 1-cycle pulse on sweep wrap or triangle turn-around
//   cfg_err      : 1-cycle pulse when a sweep config is rejected
module dds_sweep_phase_gen #(
    parameter int unsigned ACC_BITS    = 32,
    parameter int unsigned PHASE_BITS  = 13,
    parameter int unsigned DITHER_BITS = 19,
    parameter int unsigned STEP_BITS   = 24
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    dds_sweep_phase_gen_if.slave  cfg,
    input  logic                  dither_ctrl,
    input  logic                  enable,
    output logic [PHASE_BITS-1:0] phase_o,
    output logic                  phase_valid,
    output logic [ACC_BITS-1:0]   fcw_o,
    output logic                  sweep_done,
    output logic                  cfg_err
);

    typedef enum logic [2:0] {IDLE, LOAD, FIXED, SWEEP_UP, SWEEP_DN} state_e;

    state_e                state_q, state_d, resume_q, resume_d, sweep_next;
    logic [ACC_BITS-1:0]   acc_q, acc_d, fcw_q, fcw_d;
    logic [31:0]           lfsr_q, lfsr_d, lfsr_next;
    logic [PHASE_BITS-1:0] phase_q, phase_d;
    logic                  pvalid_q, pvalid_d, done_q, done_d, err_q, err_d;
    // active configuration
    logic [1:0]            mode_q, mode_d;
    logic [ACC_BITS-1:0]   start_q, start_d, stop_q, stop_d;
    logic [STEP_BITS-1:0]  step_q, step_d;
    logic [PHASE_BITS-1:0] off_q, off_d;
    // configuration captured at handshake, applied (or dropped) in LOAD
    logic [1:0]            pmode_q, pmode_d;
    logic [ACC_BITS-1:0]   pstart_q, pstart_d, pstop_q, pstop_d;
    logic [STEP_BITS-1:0]  pstep_q, pstep_d;
    logic [PHASE_BITS-1:0] poff_q, poff_d;
    logic [31:0]           pseed_q, pseed_d;

    logic                  cfg_ready, fire, running, sweep_cfg;
    logic [ACC_BITS:0]     up_sum, dn_diff;
    logic [ACC_BITS-1:0]   dith_sum;

    assign cfg_ready     = (state_q != LOAD);
    assign cfg.cfg_ready = cfg_ready;
    assign fire          = cfg.cfg_valid && cfg_ready;
    assign sweep_cfg     = (cfg.cfg_mode == 2'b01) || (cfg.cfg_mode == 2'b10);

    // LOAD only runs the accumulator if a config was already active before it
    assign running = (state_q == LOAD) ? (resume_q != IDLE) : (state_q != IDLE);

    // Galois form of x^32+x^22+x^2+x+1
    assign lfsr_next = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? 32'h8020_0003 : 32'h0);

    assign dith_sum = acc_q + (dither_ctrl ? ACC_BITS'(lfsr_q[DITHER_BITS-1:0]) : '0);
    // one extra bit so the bound compare cannot be fooled by overflow/underflow
    assign up_sum   = {1'b0, fcw_q} + {1'b0, ACC_BITS'(step_q)};
    assign dn_diff  = {1'b0, fcw_q} - {1'b0, ACC_BITS'(step_q)};

    always_comb begin
        state_d    = state_q;
        resume_d   = resume_q;
        sweep_next = state_q;
        acc_d      = acc_q;
        fcw_d      = fcw_q;
        lfsr_d     = lfsr_q;
        phase_d    = phase_q;
        pvalid_d   = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        mode_d     = mode_q;
        start_d    = start_q;
        stop_d     = stop_q;
        step_d     = step_q;
        off_d      = off_q;
        pmode_d    = pmode_q;
        pstart_d   = pstart_q;
        pstop_d    = pstop_q;
        pstep_d    = pstep_q;
        poff_d     = poff_q;
        pseed_d    = pseed_q;

        if (running && enable) begin
            acc_d    = acc_q + fcw_q;
            lfsr_d   = lfsr_next;
            phase_d  = dith_sum[ACC_BITS-1 -: PHASE_BITS] + off_q;
            pvalid_d = 1'b1;
            case (state_q)
                SWEEP_UP: begin
                    if (up_sum >= {1'b0, stop_q}) begin
                        done_d = 1'b1;
                        if (mode_q == 2'b10) begin
                            fcw_d      = stop_q;
                            sweep_next = SWEEP_DN;
                        end else begin
                            fcw_d = start_q;
                        end
                    end else begin
                        fcw_d = up_sum[ACC_BITS-1:0];
                    end
                end
                SWEEP_DN: begin
                    if (dn_diff[ACC_BITS] || (dn_diff[ACC_BITS-1:0] <= start_q)) begin
                        done_d     = 1'b1;
                        fcw_d      = start_q;
                        sweep_next = SWEEP_UP;
                    end else begin
                        fcw_d = dn_diff[ACC_BITS-1:0];
                    end
                end
                default: ;
            endcase
        end

        state_d = sweep_next;

        if (state_q == LOAD) begin
            // err_q was computed at handshake and is the cfg_err pulse of this cycle
            if (err_q) begin
                state_d = resume_q;
            end else begin
                mode_d  = pmode_q;
                start_d = pstart_q;
                stop_d  = pstop_q;
                step_d  = pstep_q;
                off_d   = poff_q;
                fcw_d   = pstart_q;
                lfsr_d  = (pseed_q == '0) ? 32'd1 : pseed_q;
                state_d = ((pmode_q == 2'b01) || (pmode_q == 2'b10)) ? SWEEP_UP : FIXED;
            end
        end else if (fire) begin
            // a sweep bound hit in this same cycle is already folded into sweep_next
            pmode_d  = cfg.cfg_mode;
            pstart_d = cfg.cfg_fcw_start;
            pstop_d  = cfg.cfg_fcw_stop;
            pstep_d  = cfg.cfg_step;
            poff_d   = cfg.cfg_phase_off;
            pseed_d  = cfg.cfg_seed;
            err_d    = sweep_cfg && ((cfg.cfg_fcw_start >= cfg.cfg_fcw_stop) || (cfg.cfg_step == '0));
            resume_d = sweep_next;
            state_d  = LOAD;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q  <= IDLE;
            resume_q <= IDLE;
            acc_q    <= '0;
            fcw_q    <= '0;
            lfsr_q   <= 32'd1;
            phase_q  <= '0;
            pvalid_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            mode_q   <= '0;
            start_q  <= '0;
            stop_q   <= '0;
            step_q   <= '0;
            off_q    <= '0;
            pmode_q  <= '0;
            pstart_q <= '0;
            pstop_q  <= '0;
            pstep_q  <= '0;
            poff_q   <= '0;
            pseed_q  <= '0;
        end else begin
            state_q  <= state_d;
            resume_q <= resume_d;
            acc_q    <= acc_d;
            fcw_q    <= fcw_d;
            lfsr_q   <= lfsr_d;
            phase_q  <= phase_d;
            pvalid_q <= pvalid_d;
            done_q   <= done_d;
            err_q    <= err_d;
            mode_q   <= mode_d;
            start_q  <= start_d;
            stop_q   <= stop_d;
            step_q   <= step_d;
            off_q    <= off_d;
            pmode_q  <= pmode_d;
            pstart_q <= pstart_d;
            pstop_q  <= pstop_d;
            pstep_q  <= pstep_d;
            poff_q   <= poff_d;
            pseed_q  <= pseed_d;
        end
    end

    assign phase_o     = phase_q;
    assign phase_valid = pvalid_q;
    assign fcw_o       = fcw_q;
    assign sweep_done  = done_q;
    assign cfg_err     = err_q;

endmodule

// File: tb/tb_dds_sweep_phase_gen.sv
module tb_dds_sweep_phase_gen;

    logic        CLK;
    logic        RSTN;
    logic        dither_ctrl;
    logic        enable;
    logic [12:0] phase_o;
    logic        phase_valid;
    logic [31:0] fcw_o;
    logic        sweep_done;
    logic        cfg_err;

    int n_tests;
    int n_fail;

    dds_sweep_phase_gen_if #(.ACC_BITS(32), .PHASE_BITS(13), .STEP_BITS(24)) cfg_if ();

    dds_sweep_phase_gen #(
        .ACC_BITS(32), .PHASE_BITS(13), .DITHER_BITS(19), .STEP_BITS(24)
    ) dut (
        .CLK(CLK), .RSTN(RSTN), .cfg(cfg_if),
        .dither_ctrl(dither_ctrl), .enable(enable),
        .phase_o(phase_o), .phase_valid(phase_valid), .fcw_o(fcw_o),
        .sweep_done(sweep_done), .cfg_err(cfg_err)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit [31:0] m_acc, m_fcw, m_lfsr, m_start, m_stop, pm_start, pm_stop, pm_seed;
    bit [23:0] m_step, pm_step;
    bit [12:0] m_off, m_phase, pm_off;
    bit [1:0]  m_mode, pm_mode;
    bit        m_active, m_down, m_pending, m_bad, m_pv, m_done, m_err;

    task automatic model_reset();
        m_acc = 0; m_fcw = 0; m_lfsr = 1; m_phase = 0; m_off = 0;
        m_start = 0; m_stop = 0; m_step = 0; m_mode = 0;
        m_active = 0; m_down = 0; m_pending = 0; m_bad = 0;
        m_pv = 0; m_done = 0; m_err = 0;
    endtask

    task automatic model_step();
        bit [31:0] tmp;
        longint    nf;
        bit        n_done, n_err;
        n_done = 0;
        n_err  = 0;
        m_pv   = 0;
        if (enable && m_active) begin
            tmp     = m_acc + (dither_ctrl ? (m_lfsr % 32'h0008_0000) : 32'h0);
            m_phase = 13'(tmp >> 19) + m_off;
            m_pv    = 1;
            m_acc   = m_acc + m_fcw;
            m_lfsr  = m_lfsr[0] ? ((m_lfsr >> 1) ^ 32'h8020_0003) : (m_lfsr >> 1);
            if (!m_pending && (m_mode == 2'd1 || m_mode == 2'd2)) begin
                if (!m_down) begin
                    nf = longint'(m_fcw) + longint'(m_step);
                    if (nf >= longint'(m_stop)) begin
                        n_done = 1;
                        if (m_mode == 2'd2) begin m_fcw = m_stop; m_down = 1; end
                        else m_fcw = m_start;
                    end else m_fcw = 32'(nf);
                end else begin
                    nf = longint'(m_fcw) - longint'(m_step);
                    if (nf <= longint'(m_start)) begin
                        n_done = 1; m_fcw = m_start; m_down = 0;
                    end else m_fcw = 32'(nf);
                end
            end
        end
        if (m_pending) begin
            m_pending = 0;
            if (!m_bad) begin
                m_mode = pm_mode; m_start = pm_start; m_stop = pm_stop;
                m_step = pm_step; m_off = pm_off; m_fcw = pm_start;
                m_lfsr = (pm_seed == 0) ? 32'd1 : pm_seed;
                m_down = 0; m_active = 1;
            end
        end else if (cfg_if.cfg_valid) begin
            pm_mode = cfg_if.cfg_mode; pm_start = cfg_if.cfg_fcw_start;
            pm_stop = cfg_if.cfg_fcw_stop; pm_step = cfg_if.cfg_step;
            pm_off = cfg_if.cfg_phase_off; pm_seed = cfg_if.cfg_seed;
            m_bad = (pm_mode == 2'd1 || pm_mode == 2'd2) && (pm_start >= pm_stop || pm_step == 0);
            n_err = m_bad;
            m_pending = 1;
        end
        m_done = n_done;
        m_err  = n_err;
    endtask

    always @(posedge CLK) begin
        if (!RSTN) model_reset();
        else model_step();
        #1;
        chk("phase_o", 64'(phase_o), 64'(m_phase));
        chk("phase_valid", 64'(phase_valid), 64'(m_pv));
        chk("fcw_o", 64'(fcw_o), 64'(m_fcw));
        chk("sweep_done", 64'(sweep_done), 64'(m_done));
        chk("cfg_err", 64'(cfg_err), 64'(m_err));
        chk("cfg_ready", 64'(cfg_if.cfg_ready), 64'(!m_pending));
    end

    // ---------------- stimulus ----------------
    task automatic do_cfg(input bit [1:0] mode, input bit [31:0] start, input bit [31:0] stop,
                          input bit [23:0] step, input bit [12:0] off, input bit [31:0] seed);
        @(negedge CLK);
        cfg_if.cfg_mode = mode; cfg_if.cfg_fcw_start = start; cfg_if.cfg_fcw_stop = stop;
        cfg_if.cfg_step = step; cfg_if.cfg_phase_off = off; cfg_if.cfg_seed = seed;
        cfg_if.cfg_valid = 1'b1;
        @(negedge CLK);
        cfg_if.cfg_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_phase"}, 64'(phase_o), 64'h0);
        chk({tag, "_pvalid"}, 64'(phase_valid), 64'h0);
        chk({tag, "_fcw"}, 64'(fcw_o), 64'h0);
        chk({tag, "_done"}, 64'(sweep_done), 64'h0);
        chk({tag, "_err"}, 64'(cfg_err), 64'h0);
        chk({tag, "_ready"}, 64'(cfg_if.cfg_ready), 64'h1);
    endtask

    bit [31:0] exp_fcw3 [7] = '{100, 400, 700, 100, 400, 700, 100};
    bit        exp_dn3  [7] = '{0, 0, 0, 1, 0, 0, 1};
    bit [31:0] exp_fcw4 [8] = '{0, 300, 600, 900, 600, 300, 0, 300};
    bit        exp_dn4  [8] = '{0, 0, 0, 1, 0, 0, 1, 0};

    initial begin
        n_tests = 0;
        n_fail  = 0;
        model_reset();
        RSTN = 1'b0;
        dither_ctrl = 1'b0;
        enable = 1'b1;
        cfg_if.cfg_valid = 1'b0; cfg_if.cfg_mode = '0; cfg_if.cfg_fcw_start = '0;
        cfg_if.cfg_fcw_stop = '0; cfg_if.cfg_step = '0; cfg_if.cfg_phase_off = '0;
        cfg_if.cfg_seed = '0;
        repeat (3) @(negedge CLK);
        check_reset_outputs("reset");
        RSTN = 1'b1;
        repeat (2) @(negedge CLK);
        chk("idle_pvalid", 64'(phase_valid), 64'h0);

        // 1: fixed FCW; after 10 accumulations phase = (10*0x333333)>>19 = 0x3F
        do_cfg(2'b00, 32'h0033_3333, 32'h0, 24'h0, 13'h0, 32'h1);
        repeat (12) @(negedge CLK);
        chk("fixed_phase10", 64'(phase_o), 64'h3F);
        chk("fixed_fcw", 64'(fcw_o), 64'h0033_3333);
        repeat (1000) @(negedge CLK);

        // 2: phase-continuous retune
        do_cfg(2'b00, 32'h0013_3333, 32'h0, 24'h0, 13'h0, 32'h1);
        chk("retune_ready_load", 64'(cfg_if.cfg_ready), 64'h0);
        chk("retune_fcw_old", 64'(fcw_o), 64'h0033_3333);
        @(negedge CLK);
        chk("retune_fcw_new", 64'(fcw_o), 64'h0013_3333);
        chk("retune_ready", 64'(cfg_if.cfg_ready), 64'h1);
        repeat (200) @(negedge CLK);

        // 3: wrap sweep
        do_cfg(2'b01, 32'd100, 32'd1000, 24'd300, 13'h0, 32'h1);
        for (int i = 0; i < 7; i++) begin
            @(negedge CLK);
            chk("wrap_fcw", 64'(fcw_o), 64'(exp_fcw3[i]));
            chk("wrap_done", 64'(sweep_done), 64'(exp_dn3[i]));
        end

        // 4: triangle sweep
        do_cfg(2'b10, 32'd0, 32'd900, 24'd300, 13'h0, 32'h1);
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            chk("tri_fcw", 64'(fcw_o), 64'(exp_fcw4[i]));
            chk("tri_done", 64'(sweep_done), 64'(exp_dn4[i]));
        end
        repeat (20) @(negedge CLK);

        // 5: rejected configs leave a fixed FCW untouched
        do_cfg(2'b00, 32'h0000_1000, 32'h0, 24'h0, 13'h100, 32'h1);
        repeat (3) @(negedge CLK);
        do_cfg(2'b01, 32'd500, 32'd500, 24'd10, 13'h0, 32'h5);
        chk("err_pulse", 64'(cfg_err), 64'h1);
        @(negedge CLK);
        chk("err_clear", 64'(cfg_err), 64'h0);
        chk("err_fcw_kept", 64'(fcw_o), 64'h0000_1000);
        do_cfg(2'b10, 32'd10, 32'd20, 24'd0, 13'h0, 32'h5);
        chk("err_step0", 64'(cfg_err), 64'h1);
        repeat (3) @(negedge CLK);
        chk("err_fcw_kept2", 64'(fcw_o), 64'h0000_1000);

        // seed 0 behaves as seed 1 (checked through the dithered phase)
        dither_ctrl = 1'b1;
        do_cfg(2'b00, 32'h0001_2345, 32'h0, 24'h0, 13'h7, 32'h0);
        repeat (50) @(negedge CLK);

        // enable low: everything holds
        enable = 1'b0;
        repeat (10) @(negedge CLK);
        chk("hold_pvalid", 64'(phase_valid), 64'h0);
        enable = 1'b1;
        dither_ctrl = 1'b0;
        repeat (5) @(negedge CLK);

        // asynchronous reset mid-sweep
        do_cfg(2'b10, 32'd1000, 32'd50000, 24'd777, 13'h3, 32'h9);
        repeat (40) @(negedge CLK);
        RSTN = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        @(negedge CLK);
        RSTN = 1'b1;
        repeat (2) @(negedge CLK);

        // 6: dither against the model for 10k cycles
        dither_ctrl = 1'b1;
        do_cfg(2'b00, 32'h0033_3333, 32'h0, 24'h0, 13'h0, 32'd1234567);
        repeat (10000) @(negedge CLK);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
